// File: rtl/fs_pkg.sv
// Shared definitions for the registered full subtractor.
//   FS_MAX_WIDTH : widest operand the subtractor is built for
//   fs_result_t  : difference/borrow pair, sized for the widest build;
//                  narrower users zero-extend diff
package fs_pkg;

  localparam int FS_MAX_WIDTH = 64;

  typedef struct packed {
    logic [FS_MAX_WIDTH-1:0] diff;
    logic                    borrow;
  } fs_result_t;

endpackage

// File: rtl/fs_bit_cell.sv
// Combinational 1-bit full subtractor cell: computes a - b - bi.
// Ports:
//   a_i  : minuend bit
//   b_i  : subtrahend bit
//   bi_i : borrow-in
//   d_o  : difference bit
//   bo_o : borrow-out
module fs_bit_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bi_i,
  output logic d_o,
  output logic bo_o
);

  assign d_o  = a_i ^ b_i ^ bi_i;
  // A borrow is generated when a=0,b=1. When a==b, the incoming borrow
  // passes straight through.
  assign bo_o = (~a_i & b_i) | (~(a_i ^ b_i) & bi_i);

endmodule

// File: rtl/full_subtractor_reg.sv
// Registered, width-parameterised full subtractor: a - b - bin through a
// ripple-borrow chain of fs_bit_cell, with the result captured on the
// rising edge. Latency 1 cycle, full throughput, no backpressure.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_valid  : operands valid this cycle
//   a, b      : unsigned minuend / subtrahend (WIDTH bits)
//   bin       : borrow-in
//   diff      : registered (a - b - bin) mod 2^WIDTH
//   borrow    : registered borrow-out (a < b + bin)
//   out_valid : diff/borrow were produced from a valid input at the last edge
module full_subtractor_reg
  import fs_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > FS_MAX_WIDTH) begin : g_width_chk
    $error("full_subtractor_reg: WIDTH out of range 1..%0d", FS_MAX_WIDTH);
  end

  // bchain[i] is the borrow into cell i; bchain[WIDTH] is the final borrow.
  logic [WIDTH:0]   bchain;
  logic [WIDTH-1:0] diff_d;
  logic             borrow_d;

  assign bchain[0] = bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fs_bit_cell u_cell (
      .a_i  (a[i]),
      .b_i  (b[i]),
      .bi_i (bchain[i]),
      .d_o  (diff_d[i]),
      .bo_o (bchain[i+1])
    );
  end

  assign borrow_d = bchain[WIDTH];

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             valid_q;

  // Result registers only load on a valid input so an idle cycle leaves
  // the last result visible; out_valid drops for that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        diff_q   <= diff_d;
        borrow_q <= borrow_d;
      end
    end
  end

  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_full_subtractor_reg.sv
module tb_full_subtractor_reg;
  import fs_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic       v1 = 1'b0, bin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, d1;
  logic       bo1, ov1;

  logic       v8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, d8;
  logic       bo8, ov8;

  logic        v16 = 1'b0, bin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, d16;
  logic        bo16, ov16;

  full_subtractor_reg #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .bin(bin1),
    .diff(d1), .borrow(bo1), .out_valid(ov1));
  full_subtractor_reg #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .bin(bin8),
    .diff(d8), .borrow(bo8), .out_valid(ov8));
  full_subtractor_reg #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .bin(bin16),
    .diff(d16), .borrow(bo16), .out_valid(ov16));

  typedef struct {
    logic [63:0] diff;
    logic        borrow;
    logic        ov;
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic        chk_id;
  } exp_t;

  exp_t       sb[$];
  fs_result_t last[3];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus on DUT idx (0:W1, 1:W8, 2:W16); the others idle.
  task automatic step(input string tag, input int idx, input logic [63:0] a,
                      input logic [63:0] b, input logic bin, input logic v,
                      input logic r);
    int          w;
    logic [63:0] m, od, lhs, rhs;
    logic [64:0] full;
    logic        ob, ov;
    exp_t        e;
    w = (idx == 0) ? 1 : (idx == 1) ? 8 : 16;
    m = (64'd1 << w) - 64'd1;
    rst = r;
    v1 = 1'b0; v8 = 1'b0; v16 = 1'b0;
    case (idx)
      0: begin v1 = v; a1 = a[0:0]; b1 = b[0:0]; bin1 = bin; end
      1: begin v8 = v; a8 = a[7:0]; b8 = b[7:0]; bin8 = bin; end
      default: begin v16 = v; a16 = a[15:0]; b16 = b[15:0]; bin16 = bin; end
    endcase
    full = {1'b0, a & m} - {1'b0, b & m} - {64'd0, bin};
    if (r) begin
      for (int k = 0; k < 3; k++) last[k] = '{diff: 64'd0, borrow: 1'b0};
    end else if (v) begin
      last[idx] = '{diff: full[63:0] & m, borrow: full[64]};
    end
    e.diff = last[idx].diff; e.borrow = last[idx].borrow; e.ov = v & ~r;
    e.a = a & m; e.b = b & m; e.bin = bin; e.chk_id = (idx == 2) && v && !r;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    case (idx)
      0: begin od = {63'd0, d1}; ob = bo1; ov = ov1; end
      1: begin od = {56'd0, d8}; ob = bo8; ov = ov8; end
      default: begin od = {48'd0, d16}; ob = bo16; ov = ov16; end
    endcase
    chk({tag, ".diff"}, od, e.diff);
    chk({tag, ".borrow"}, {63'd0, ob}, {63'd0, e.borrow});
    chk({tag, ".out_valid"}, {63'd0, ov}, {63'd0, e.ov});
    if (e.chk_id) begin
      lhs = od + e.b + {63'd0, e.bin};
      rhs = e.a + ({63'd0, ob} << 16);
      chk({tag, ".identity"}, lhs, rhs);
    end
  endtask

  initial begin
    // Reset held two cycles with a live operand pair; must not leak through.
    step("rst0", 0, 64'd1, 64'd0, 1'b0, 1'b1, 1'b1);
    step("rst1", 0, 64'd1, 64'd0, 1'b0, 1'b1, 1'b1);

    // WIDTH=1 truth table, first valid result one edge after reset drops.
    step("tt000", 0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);
    step("tt010", 0, 64'd0, 64'd1, 1'b0, 1'b1, 1'b0);
    step("tt100", 0, 64'd1, 64'd0, 1'b0, 1'b1, 1'b0);
    step("tt110", 0, 64'd1, 64'd1, 1'b0, 1'b1, 1'b0);
    step("tt001", 0, 64'd0, 64'd0, 1'b1, 1'b1, 1'b0);
    step("tt011", 0, 64'd0, 64'd1, 1'b1, 1'b1, 1'b0);
    step("tt101", 0, 64'd1, 64'd0, 1'b1, 1'b1, 1'b0);
    step("tt111", 0, 64'd1, 64'd1, 1'b1, 1'b1, 1'b0);

    // Hold on idle cycle.
    step("hold_ld", 1, 64'h50, 64'h20, 1'b0, 1'b1, 1'b0);
    step("hold_idle", 1, 64'hFF, 64'h00, 1'b0, 1'b0, 1'b0);

    // Wrap and borrow boundaries.
    step("wrap_0_ff", 1, 64'h00, 64'hFF, 1'b1, 1'b1, 1'b0);
    step("eq_bin1", 1, 64'h10, 64'h10, 1'b1, 1'b1, 1'b0);
    step("eq_bin0", 1, 64'h10, 64'h10, 1'b0, 1'b1, 1'b0);

    // Back-to-back full throughput.
    step("b2b0", 1, 64'h05, 64'h03, 1'b0, 1'b1, 1'b0);
    step("b2b1", 1, 64'h03, 64'h05, 1'b0, 1'b1, 1'b0);
    step("b2b2", 1, 64'h80, 64'h7F, 1'b1, 1'b1, 1'b0);

    // Randomised WIDTH=16 with idle cycles and reset pulses.
    for (int n = 0; n < 1000; n++) begin
      step("rand16", 2, 64'($urandom_range(0, 65535)), 64'($urandom_range(0, 65535)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
